// File: rtl/ddr_m2a_rdata_ret.sv
// Read-return path of the AXI2MBA bridge: buffers non-backpressured MBA read beats and
// replays them on the AXI R channel, tagging ID/LAST/RESP from the issued-command queue.
module ddr_m2a_rdata_ret #(
  parameter int unsigned P_DW     = 64,
  parameter int unsigned P_IDW    = 4,
  parameter int unsigned P_CDEPTH = 2,
  parameter int unsigned P_DDEPTH = 4
) (
  input  logic                CLK,
  input  logic                ZRESET,
  input  logic                CLR,
  input  logic                CMD_WE,
  input  logic [P_IDW-1:0]    CMD_ID,
  input  logic [7:0]          CMD_LEN,
  output logic                CMD_FULL,
  output logic [P_DDEPTH:0]   DBUF_FREE,
  input  logic                MBA_RVALID,
  input  logic [P_DW-1:0]     MBA_RDATA,
  input  logic                MBA_RERR,
  output logic                RVALID,
  input  logic                RREADY,
  output logic [P_DW-1:0]     RDATA,
  output logic [P_IDW-1:0]    RID,
  output logic                RLAST,
  output logic [1:0]          RRESP,
  output logic                OVF
);

  localparam int unsigned CN = 1 << P_CDEPTH;
  localparam int unsigned DN = 1 << P_DDEPTH;
  localparam int unsigned FW = P_DDEPTH + 1;

  logic [P_IDW-1:0]  cmd_id_mem  [CN];
  logic [7:0]        cmd_len_mem [CN];
  logic [P_DW:0]     dbuf_mem    [DN];

  logic [P_CDEPTH:0] cmd_wptr_q, cmd_rptr_q;
  logic [P_DDEPTH:0] dbuf_wptr_q, dbuf_rptr_q;
  logic [FW-1:0]     free_q, free_d;
  logic [7:0]        bcnt_q;
  logic              rvalid_q, rlast_q, ovf_q;
  logic [P_DW-1:0]   rdata_q;
  logic [P_IDW-1:0]  rid_q;
  logic [1:0]        rresp_q;

  logic              cmd_full, cmd_empty, dbuf_full, dbuf_empty;
  logic [8:0]        len_p1;
  logic              cmd_accept, dbuf_we, hs, load, head_last, ovf_set;
  logic [P_DW:0]     dbuf_head;

  always_comb begin
    cmd_full   = (cmd_wptr_q[P_CDEPTH] != cmd_rptr_q[P_CDEPTH]) &&
                 (cmd_wptr_q[P_CDEPTH-1:0] == cmd_rptr_q[P_CDEPTH-1:0]);
    cmd_empty  = (cmd_wptr_q == cmd_rptr_q);
    dbuf_full  = (dbuf_wptr_q[P_DDEPTH] != dbuf_rptr_q[P_DDEPTH]) &&
                 (dbuf_wptr_q[P_DDEPTH-1:0] == dbuf_rptr_q[P_DDEPTH-1:0]);
    dbuf_empty = (dbuf_wptr_q == dbuf_rptr_q);
    len_p1     = {1'b0, CMD_LEN} + 9'd1;
    cmd_accept = CMD_WE && !cmd_full && (32'(len_p1) <= 32'(free_q));
    dbuf_we    = MBA_RVALID && !dbuf_full;
    hs         = rvalid_q && RREADY;
    load       = !dbuf_empty && !cmd_empty && (!rvalid_q || RREADY);
    head_last  = (bcnt_q == cmd_len_mem[cmd_rptr_q[P_CDEPTH-1:0]]);
    dbuf_head  = dbuf_mem[dbuf_rptr_q[P_DDEPTH-1:0]];
    ovf_set    = (CMD_WE && !cmd_accept) || (MBA_RVALID && dbuf_full);
    // Accepted length fits in FW bits since it never exceeds the current credit.
    free_d     = free_q + FW'(hs) - (cmd_accept ? FW'(len_p1) : '0);
  end

  // Storage arrays carry no reset; pointers alone define occupancy.
  always_ff @(posedge CLK) begin
    if (cmd_accept) begin
      cmd_id_mem[cmd_wptr_q[P_CDEPTH-1:0]]  <= CMD_ID;
      cmd_len_mem[cmd_wptr_q[P_CDEPTH-1:0]] <= CMD_LEN;
    end
    if (dbuf_we) begin
      dbuf_mem[dbuf_wptr_q[P_DDEPTH-1:0]] <= {MBA_RERR, MBA_RDATA};
    end
  end

  always_ff @(posedge CLK or negedge ZRESET) begin
    if (!ZRESET) begin
      cmd_wptr_q  <= '0;
      cmd_rptr_q  <= '0;
      dbuf_wptr_q <= '0;
      dbuf_rptr_q <= '0;
      free_q      <= FW'(DN);
      bcnt_q      <= '0;
      rvalid_q    <= 1'b0;
      rlast_q     <= 1'b0;
      ovf_q       <= 1'b0;
      rdata_q     <= '0;
      rid_q       <= '0;
      rresp_q     <= '0;
    end else if (CLR) begin
      cmd_wptr_q  <= '0;
      cmd_rptr_q  <= '0;
      dbuf_wptr_q <= '0;
      dbuf_rptr_q <= '0;
      free_q      <= FW'(DN);
      bcnt_q      <= '0;
      rvalid_q    <= 1'b0;
      rlast_q     <= 1'b0;
      ovf_q       <= 1'b0;
      rdata_q     <= '0;
      rid_q       <= '0;
      rresp_q     <= '0;
    end else begin
      if (cmd_accept) cmd_wptr_q <= cmd_wptr_q + 1'b1;
      if (dbuf_we)    dbuf_wptr_q <= dbuf_wptr_q + 1'b1;
      if (ovf_set)    ovf_q <= 1'b1;
      free_q <= free_d;
      if (load) begin
        dbuf_rptr_q <= dbuf_rptr_q + 1'b1;
        rdata_q     <= dbuf_head[P_DW-1:0];
        rresp_q     <= {dbuf_head[P_DW], 1'b0};
        rid_q       <= cmd_id_mem[cmd_rptr_q[P_CDEPTH-1:0]];
        rlast_q     <= head_last;
        rvalid_q    <= 1'b1;
        if (head_last) begin
          cmd_rptr_q <= cmd_rptr_q + 1'b1;
          bcnt_q     <= '0;
        end else begin
          bcnt_q     <= bcnt_q + 8'd1;
        end
      end else if (hs) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  assign CMD_FULL  = cmd_full;
  assign DBUF_FREE = free_q;
  assign RVALID    = rvalid_q;
  assign RDATA     = rdata_q;
  assign RID       = rid_q;
  assign RLAST     = rlast_q;
  assign RRESP     = rresp_q;
  assign OVF       = ovf_q;

endmodule

// File: tb/tb_ddr_m2a_rdata_ret.sv
// Directed bench for ddr_m2a_rdata_ret: per-cycle checks plus an expected-beat queue
// consumed by a handshake monitor.
module tb_ddr_m2a_rdata_ret;

  logic        CLK = 1'b0;
  logic        ZRESET, CLR, CMD_WE, CMD_FULL, MBA_RVALID, MBA_RERR;
  logic [3:0]  CMD_ID, RID;
  logic [7:0]  CMD_LEN;
  logic [4:0]  DBUF_FREE;
  logic [63:0] MBA_RDATA, RDATA;
  logic        RVALID, RREADY, RLAST, OVF;
  logic [1:0]  RRESP;

  typedef struct packed {
    logic [63:0] data;
    logic [3:0]  id;
    logic        last;
    logic [1:0]  resp;
  } beat_t;

  beat_t exp_q[$];
  beat_t mon_e;
  int    n_checks = 0;
  int    n_errors = 0;
  logic  mon_en   = 1'b0;
  logic  rnd_rdy  = 1'b0;

  ddr_m2a_rdata_ret dut (
    .CLK(CLK), .ZRESET(ZRESET), .CLR(CLR),
    .CMD_WE(CMD_WE), .CMD_ID(CMD_ID), .CMD_LEN(CMD_LEN), .CMD_FULL(CMD_FULL),
    .DBUF_FREE(DBUF_FREE),
    .MBA_RVALID(MBA_RVALID), .MBA_RDATA(MBA_RDATA), .MBA_RERR(MBA_RERR),
    .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RID(RID), .RLAST(RLAST),
    .RRESP(RRESP), .OVF(OVF)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic issue(input logic [3:0] id, input logic [7:0] len);
    CMD_WE = 1'b1; CMD_ID = id; CMD_LEN = len;
    tick();
    CMD_WE = 1'b0;
  endtask

  task automatic send_beat(input logic [63:0] d, input logic err, input logic [3:0] id,
                           input logic last);
    MBA_RVALID = 1'b1; MBA_RDATA = d; MBA_RERR = err;
    exp_q.push_back('{data: d, id: id, last: last, resp: {err, 1'b0}});
    tick();
    MBA_RVALID = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 400; i++) begin
      if (exp_q.size() == 0 && !RVALID) return;
      tick();
    end
    check_eq("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  // Outputs only move on posedge and RREADY only moves at posedge+1, so the negedge
  // value of RVALID&RREADY is exactly what the next edge will consume.
  always @(negedge CLK) begin
    if (mon_en && RVALID && RREADY) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_beat", 64'(RDATA), 64'hx);
      end else begin
        mon_e = exp_q.pop_front();
        check_eq("mon_rdata", RDATA, mon_e.data);
        check_eq("mon_rid", 64'(RID), 64'(mon_e.id));
        check_eq("mon_rlast", 64'(RLAST), 64'(mon_e.last));
        check_eq("mon_rresp", 64'(RRESP), 64'(mon_e.resp));
      end
    end
  end

  always @(posedge CLK) begin
    if (rnd_rdy) begin
      #1;
      RREADY = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    ZRESET = 1'b0; CLR = 1'b0; CMD_WE = 1'b0; CMD_ID = '0; CMD_LEN = '0;
    MBA_RVALID = 1'b0; MBA_RDATA = '0; MBA_RERR = 1'b0; RREADY = 1'b0;
    tick(); tick();
    check_eq("rst_rvalid", 64'(RVALID), 64'd0);
    check_eq("rst_free", 64'(DBUF_FREE), 64'd16);
    check_eq("rst_full", 64'(CMD_FULL), 64'd0);
    check_eq("rst_ovf", 64'(OVF), 64'd0);
    check_eq("rst_rdata", RDATA, 64'd0);
    ZRESET = 1'b1;
    tick();

    // 1: async reset in the middle of a stalled burst with OVF already set
    issue(4'd5, 8'd7);
    issue(4'd6, 8'd15);
    check_eq("t1_ovf_set", 64'(OVF), 64'd1);
    send_beat(64'h11, 1'b0, 4'd5, 1'b0);
    send_beat(64'h22, 1'b0, 4'd5, 1'b0);
    check_eq("t1_rvalid_pre", 64'(RVALID), 64'd1);
    #2 ZRESET = 1'b0;
    #1;
    check_eq("t1_rvalid", 64'(RVALID), 64'd0);
    check_eq("t1_free", 64'(DBUF_FREE), 64'd16);
    check_eq("t1_full", 64'(CMD_FULL), 64'd0);
    check_eq("t1_ovf", 64'(OVF), 64'd0);
    check_eq("t1_rdata", RDATA, 64'd0);
    tick();
    ZRESET = 1'b1;
    exp_q.delete();
    tick();
    mon_en = 1'b1;

    // 2: single 4-beat burst streaming straight through
    RREADY = 1'b1;
    issue(4'd3, 8'd3);
    check_eq("t2_free_res", 64'(DBUF_FREE), 64'd12);
    send_beat(64'hD0, 1'b0, 4'd3, 1'b0);
    check_eq("t2_lat0", 64'(RVALID), 64'd0);
    send_beat(64'hD1, 1'b0, 4'd3, 1'b0);
    check_eq("t2_v0", 64'(RVALID), 64'd1);
    check_eq("t2_d0", RDATA, 64'hD0);
    check_eq("t2_id0", 64'(RID), 64'd3);
    check_eq("t2_l0", 64'(RLAST), 64'd0);
    check_eq("t2_free_mid", 64'(DBUF_FREE), 64'd12);
    send_beat(64'hD2, 1'b0, 4'd3, 1'b0);
    check_eq("t2_d1", RDATA, 64'hD1);
    send_beat(64'hD3, 1'b0, 4'd3, 1'b1);
    check_eq("t2_d2", RDATA, 64'hD2);
    check_eq("t2_l2", 64'(RLAST), 64'd0);
    tick();
    check_eq("t2_d3", RDATA, 64'hD3);
    check_eq("t2_l3", 64'(RLAST), 64'd1);
    tick();
    check_eq("t2_idle", 64'(RVALID), 64'd0);
    check_eq("t2_free_end", 64'(DBUF_FREE), 64'd16);

    // 3: backpressure holds the presented beat while the buffer absorbs the rest
    RREADY = 1'b0;
    issue(4'd7, 8'd5);
    for (int i = 0; i < 6; i++) send_beat(64'hB0 + 64'(i), 1'b0, 4'd7, i == 5);
    for (int i = 0; i < 5; i++) begin
      check_eq("t3_hold_v", 64'(RVALID), 64'd1);
      check_eq("t3_hold_d", RDATA, 64'hB0);
      check_eq("t3_hold_l", 64'(RLAST), 64'd0);
      tick();
    end
    check_eq("t3_free", 64'(DBUF_FREE), 64'd10);
    RREADY = 1'b1;
    wait_drain();
    check_eq("t3_free_end", 64'(DBUF_FREE), 64'd16);

    // 4: two commands, error on the final beat
    issue(4'd1, 8'd0);
    issue(4'd2, 8'd1);
    send_beat(64'hE0, 1'b0, 4'd1, 1'b1);
    send_beat(64'hE1, 1'b0, 4'd2, 1'b0);
    send_beat(64'hE2, 1'b1, 4'd2, 1'b1);
    wait_drain();
    check_eq("t4_free", 64'(DBUF_FREE), 64'd16);

    // 5: credit exhaustion and command-queue full
    issue(4'd9, 8'd15);
    check_eq("t5_free0", 64'(DBUF_FREE), 64'd0);
    issue(4'd8, 8'd0);
    check_eq("t5_ovf", 64'(OVF), 64'd1);
    check_eq("t5_free_rej", 64'(DBUF_FREE), 64'd0);
    for (int i = 0; i < 16; i++) send_beat(64'hC00 + 64'(i), 1'b0, 4'd9, i == 15);
    wait_drain();
    check_eq("t5_free_back", 64'(DBUF_FREE), 64'd16);
    check_eq("t5_ovf_sticky", 64'(OVF), 64'd1);
    CLR = 1'b1;
    tick();
    CLR = 1'b0;
    check_eq("t5_ovf_clr", 64'(OVF), 64'd0);
    for (int i = 0; i < 4; i++) issue(4'(i), 8'd0);
    check_eq("t5_full", 64'(CMD_FULL), 64'd1);
    check_eq("t5_free12", 64'(DBUF_FREE), 64'd12);
    issue(4'd4, 8'd0);
    check_eq("t5_fifth_ovf", 64'(OVF), 64'd1);
    check_eq("t5_fifth_free", 64'(DBUF_FREE), 64'd12);
    for (int i = 0; i < 4; i++) send_beat(64'hF0 + 64'(i), 1'b0, 4'(i), 1'b1);
    wait_drain();
    check_eq("t5_notfull", 64'(CMD_FULL), 64'd0);
    check_eq("t5_free_end", 64'(DBUF_FREE), 64'd16);
    CLR = 1'b1;
    tick();
    CLR = 1'b0;

    // 6: many random bursts with random RREADY, issuer honouring credit
    rnd_rdy = 1'b1;
    for (int b = 0; b < 40; b++) begin
      logic [7:0] len;
      logic [3:0] id;
      logic       ok;
      len = 8'($urandom_range(0, 15));
      id  = 4'($urandom_range(0, 15));
      ok  = 1'b0;
      for (int w = 0; w < 500; w++) begin
        if (32'(DBUF_FREE) >= 32'(len) + 1 && !CMD_FULL) begin
          ok = 1'b1;
          break;
        end
        tick();
      end
      if (!ok) begin
        check_eq("t6_credit_timeout", 64'(DBUF_FREE), 64'(len) + 1);
        break;
      end
      issue(id, len);
      for (int k = 0; k <= int'(len); k++) begin
        if ($urandom_range(0, 3) == 0) tick();
        send_beat({32'(b), 32'(k)} ^ 64'h5A5A_0000_3C3C_0000, 1'($urandom_range(0, 1)),
                  id, k == int'(len));
      end
    end
    rnd_rdy = 1'b0;
    tick();
    RREADY = 1'b1;
    wait_drain();
    check_eq("t6_free", 64'(DBUF_FREE), 64'd16);
    check_eq("t6_ovf", 64'(OVF), 64'd0);
    check_eq("t6_full", 64'(CMD_FULL), 64'd0);

    // CLR in the middle of a stalled burst
    mon_en = 1'b0;
    RREADY = 1'b0;
    issue(4'd6, 8'd7);
    for (int i = 0; i < 3; i++) send_beat(64'h700 + 64'(i), 1'b0, 4'd6, 1'b0);
    exp_q.delete();
    check_eq("t6_pre_clr_v", 64'(RVALID), 64'd1);
    CLR = 1'b1;
    tick();
    CLR = 1'b0;
    check_eq("t6_clr_v", 64'(RVALID), 64'd0);
    check_eq("t6_clr_free", 64'(DBUF_FREE), 64'd16);
    check_eq("t6_clr_full", 64'(CMD_FULL), 64'd0);
    RREADY = 1'b1;
    tick(); tick(); tick();
    check_eq("t6_clr_flushed", 64'(RVALID), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
